// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing and the sync/blank record carried alongside each pixel
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;
  localparam int DEF_NUM_IMG = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_MEM_LAT = 1;
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic img;
  } vga_sig_t;
  localparam vga_sig_t SIG_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, img: 1'b0};
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: tick-enabled shift register that lines sync/blank up with returning pixel data
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     tick,
  input  vga_sig_t d,
  output vga_sig_t q
);
  vga_sig_t pipe [DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= SIG_IDLE;
    end else if (tick) begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/vga_stream_ctrl.sv
// vga_stream_ctrl: VGA timing generator streaming a stored grayscale image from byte memory
module vga_stream_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int NUM_IMG = DEF_NUM_IMG,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [(NUM_IMG > 1 ? $clog2(NUM_IMG) : 1)-1:0] image_select,
  input  logic [7:0]                                     pix_data,
  output logic [ADDR_W-1:0]                              video_address,
  output logic                                           pixlclk,
  output logic                                           hsync,
  output logic                                           vsync,
  output logic                                           sync_b,
  output logic                                           blank_b,
  output logic [7:0]                                     R,
  output logic [7:0]                                     G,
  output logic [7:0]                                     B,
  output logic                                           frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int SW = NUM_IMG > 1 ? $clog2(NUM_IMG) : 1;
  logic              ph, tick, h_end, v_end;
  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [31:0]       h32, v32;
  logic [SW-1:0]     sel_latched, sel_in, sel_eff;
  logic [ADDR_W-1:0] line_off;
  vga_sig_t          raw, dly;
  // image bases are a mux of constants, so no multiplier is built
  function automatic logic [ADDR_W-1:0] img_base(input logic [SW-1:0] s);
    img_base = '0;
    for (int i = 1; i < NUM_IMG; i++)
      if (s == SW'(i)) img_base = ADDR_W'(i * IMG_W * IMG_H);
  endfunction
  assign tick = ph;
  assign h32 = 32'(hcnt);
  assign v32 = 32'(vcnt);
  assign h_end = hcnt == HW'(H_TOTAL - 1);
  assign v_end = vcnt == VW'(V_TOTAL - 1);
  assign frame_start = tick && hcnt == '0 && vcnt == '0;
  assign sel_in = ({1'b0, image_select} >= (SW+1)'(NUM_IMG)) ? '0 : image_select;
  assign sel_eff = frame_start ? sel_in : sel_latched;
  assign raw.hs = !(h32 >= H_ACTIVE + H_FP && h32 < H_ACTIVE + H_FP + H_SYNC);
  assign raw.vs = !(v32 >= V_ACTIVE + V_FP && v32 < V_ACTIVE + V_FP + V_SYNC);
  assign raw.act = h32 < H_ACTIVE && v32 < V_ACTIVE;
  assign raw.img = h32 < IMG_W && v32 < IMG_H;
  // line_off tracks vcnt*IMG_W by accumulation instead of multiplying
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ph <= 1'b0;
      pixlclk <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
      sel_latched <= '0;
      line_off <= '0;
      video_address <= '0;
    end else begin
      ph <= !ph;
      pixlclk <= ph;
      if (tick) begin
        hcnt <= h_end ? '0 : hcnt + 1'b1;
        if (h_end) begin
          vcnt <= v_end ? '0 : vcnt + 1'b1;
          line_off <= v_end ? '0 : line_off + ADDR_W'(IMG_W);
        end
        if (frame_start) sel_latched <= sel_eff;
        if (raw.img) video_address <= img_base(sel_eff) + line_off + ADDR_W'(hcnt);
      end
    end
  vga_delay_line #(.DEPTH(MEM_LAT + 1)) u_dly (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .d(raw),
    .q(dly)
  );
  assign hsync = dly.hs;
  assign vsync = dly.vs;
  assign blank_b = dly.act;
  assign sync_b = 1'b1;
  assign R = (dly.img && dly.act) ? pix_data : 8'd0;
  assign G = R;
  assign B = R;
endmodule

// File: tb/tb_vga_stream_ctrl.sv
// tb_vga_stream_ctrl: scoreboard bench for vga_stream_ctrl with memory latency 1 and 3
module tb_vga_stream_ctrl;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2, VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int IW = 4, IH = 2, NI = 3;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FRAME = HT * VT;
  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
    logic [7:0] px;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] image_select = 2'd1;
  logic tk;
  int e, pidx, fsel, checks, errors, npop;
  always #5 clk = ~clk;
  assign tk = rst_n && e[0];
  function automatic int map_sel(input logic [1:0] s);
    return (int'(s) >= NI) ? 0 : int'(s);
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, x, $time);
    end
  endtask
  // e counts clk edges since release; pidx is the next pixel to be ticked
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e <= 0;
      pidx <= 0;
      fsel <= 0;
    end else begin
      e <= e + 1;
      if (tk) begin
        pidx <= pidx + 1;
        if (pidx % FRAME == 0) fsel <= map_sel(image_select);
      end
    end
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 1) ? 3 : 1;
    logic [31:0] va;
    logic [7:0] pd, r, gg, b;
    logic pc, hs, vs, sb, bl, fs;
    logic [7:0] mp [L];
    exp_t q[$];
    int aq[$];
    int last_a;
    vga_stream_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .IMG_W(IW), .IMG_H(IH), .NUM_IMG(NI), .ADDR_W(32), .MEM_LAT(L)
    ) dut (
      .clk(clk), .reset(rst_n), .image_select(image_select), .pix_data(pd),
      .video_address(va), .pixlclk(pc), .hsync(hs), .vsync(vs), .sync_b(sb),
      .blank_b(bl), .R(r), .G(gg), .B(b), .frame_start(fs)
    );
    // memory returns addr[7:0], L pixel ticks after the address is presented
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i < L; i++) mp[i] <= 8'd0;
      end else if (tk) begin
        mp[0] <= va[7:0];
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
      end
    assign pd = mp[L-1];
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        q.delete();
        aq.delete();
        last_a = 0;
      end else if (tk) begin
        int p, h, v, s, a;
        logic img, act;
        p = pidx % FRAME;
        h = p % HT;
        v = p / HT;
        s = (p == 0) ? map_sel(image_select) : fsel;
        img = h < IW && v < IH;
        act = h < HA && v < VA;
        a = s * IW * IH + v * IW + h;
        if (img) last_a = a;
        q.push_back('{hs: !(h >= HA + HF && h < HA + HF + HS),
                      vs: !(v >= VA + VF && v < VA + VF + VS),
                      bl: act, px: (act && img) ? 8'(a) : 8'd0});
        aq.push_back(last_a);
      end
    always @(negedge clk)
      if (!rst_n) begin
        chk($sformatf("L%0d reset_outputs", L), 32'({hs, vs, bl, fs, pc, r, gg, b}), {5'b11000, 24'd0});
        chk($sformatf("L%0d reset_address", L), va, 0);
      end else begin
        chk($sformatf("L%0d pixlclk", L), 32'(pc), 32'(e > 0 && !e[0]));
        chk($sformatf("L%0d frame_start", L), 32'(fs), 32'(tk && pidx % FRAME == 0));
        chk($sformatf("L%0d sync_b", L), 32'(sb), 1);
        if (pc) begin
          if (aq.size() > 0) chk($sformatf("L%0d address", L), va, aq.pop_front());
          if (q.size() > L) begin
            exp_t x;
            x = q.pop_front();
            npop++;
            chk($sformatf("L%0d hsync", L), 32'(hs), 32'(x.hs));
            chk($sformatf("L%0d vsync", L), 32'(vs), 32'(x.vs));
            chk($sformatf("L%0d blank_b", L), 32'(bl), 32'(x.bl));
            chk($sformatf("L%0d rgb", L), 32'({r, gg, b}), 32'({3{x.px}}));
          end
        end
      end
    always @(negedge rst_n)
      if ($time > 0) begin
        #1;
        chk($sformatf("L%0d async_reset_outputs", L), 32'({hs, vs, bl, fs, pc, r, gg, b}), {5'b11000, 24'd0});
        chk($sformatf("L%0d async_reset_address", L), va, 0);
      end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      image_select = 2'($urandom_range(0, 3));
    end
    n = 0;
    while (pidx % FRAME != 3 * HT + 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pixel_5_3", 32'(n < 1000), 1);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    image_select = 2'd1;
    repeat (600) @(negedge clk);
    chk("scoreboard_activity", 32'(npop > 1000), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
